// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: N_MBOX standard-ID mailboxes, lowest-ID-first offer to the
// packet layer over req/ack, with per-frame retry limit and deferred abort handling.
module can_tx_scheduler #(
    parameter int N_MBOX      = 4,
    parameter int RETRY_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [$clog2(N_MBOX)-1:0] wr_sel,
    input  logic [10:0]               wr_id,
    input  logic [3:0]                wr_len,
    input  logic [63:0]               wr_data,
    input  logic                      abort_en,
    input  logic [$clog2(N_MBOX)-1:0] abort_sel,
    output logic [N_MBOX-1:0]         mb_busy,
    output logic [N_MBOX-1:0]         done_pulse,
    output logic [N_MBOX-1:0]         fail_pulse,
    output logic                      pkt_req,
    input  logic                      pkt_ack,
    output logic [10:0]               pkt_id,
    output logic [3:0]                pkt_len,
    output logic [63:0]               pkt_data,
    input  logic                      pkt_done,
    input  logic                      pkt_lost,
    input  logic                      pkt_err
);
    localparam int SW = $clog2(N_MBOX);

    typedef enum logic [1:0] {IDLE, PICK, REQ, BUSY} state_t;
    state_t state, state_nxt;

    logic [10:0] mb_id   [N_MBOX];
    logic [3:0]  mb_len  [N_MBOX];
    logic [63:0] mb_data [N_MBOX];
    logic [7:0]  retry   [N_MBOX];
    logic [SW-1:0] sel;
    logic          abort_flag;

    logic              accept, abort_hit, in_flight, abort_sel_hit, aborted;
    logic              outcome, done_sel, fail_sel, retry_upd, pick_found;
    logic [SW-1:0]     pick_idx;
    logic [7:0]        retry_inc;
    logic [N_MBOX-1:0] abort_mask, eligible, busy_nxt, done_nxt, fail_nxt;

    always_comb begin
        accept        = wr_en && !mb_busy[wr_sel];
        abort_hit     = abort_en && mb_busy[abort_sel];
        in_flight     = (state == REQ) || (state == BUSY);
        abort_sel_hit = abort_hit && in_flight && (abort_sel == sel);
        abort_mask    = '0;
        if (abort_hit && !abort_sel_hit) abort_mask[abort_sel] = 1'b1;
        aborted       = abort_flag || abort_sel_hit;

        // An abort landing in PICK must not let the aborted mailbox win this round
        eligible   = mb_busy & ~abort_mask;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_MBOX; i++) begin
            if (eligible[i] && (!pick_found || mb_id[i] < mb_id[pick_idx])) begin
                pick_found = 1'b1;
                pick_idx   = SW'(i);
            end
        end

        outcome   = (state == BUSY) && (pkt_done || pkt_err || pkt_lost);
        retry_inc = (retry[sel] == 8'hFF) ? 8'hFF : retry[sel] + 8'd1;
        done_sel  = 1'b0;
        fail_sel  = 1'b0;
        retry_upd = 1'b0;
        if (outcome) begin
            if (pkt_done) begin
                done_sel = 1'b1;
            end else if (aborted) begin
                fail_sel = 1'b1;
            end else if (pkt_err) begin
                retry_upd = 1'b1;
                fail_sel  = (RETRY_LIMIT != 0) && (retry_inc == 8'(RETRY_LIMIT));
            end
        end

        busy_nxt = mb_busy & ~abort_mask;
        if (done_sel || fail_sel) busy_nxt[sel] = 1'b0;
        if (accept) busy_nxt[wr_sel] = 1'b1;
        done_nxt      = '0;
        done_nxt[sel] = done_sel;
        fail_nxt      = abort_mask;
        if (fail_sel) fail_nxt[sel] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|mb_busy) state_nxt = PICK;
            PICK: state_nxt = pick_found ? REQ : IDLE;
            REQ:  if (pkt_ack) state_nxt = BUSY;
            BUSY: if (outcome) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mb_busy    <= '0;
            done_pulse <= '0;
            fail_pulse <= '0;
            pkt_req    <= 1'b0;
            pkt_id     <= '0;
            pkt_len    <= '0;
            pkt_data   <= '0;
            sel        <= '0;
            abort_flag <= 1'b0;
            for (int i = 0; i < N_MBOX; i++) retry[i] <= '0;
        end else begin
            mb_busy    <= busy_nxt;
            done_pulse <= done_nxt;
            fail_pulse <= fail_nxt;
            if (outcome)            abort_flag <= 1'b0;
            else if (abort_sel_hit) abort_flag <= 1'b1;
            if (accept)    retry[wr_sel] <= '0;
            if (retry_upd) retry[sel]    <= retry_inc;
            if (state == PICK && pick_found) begin
                sel      <= pick_idx;
                pkt_id   <= mb_id[pick_idx];
                pkt_len  <= mb_len[pick_idx];
                pkt_data <= mb_data[pick_idx];
                pkt_req  <= 1'b1;
            end
            if (state == REQ && pkt_ack) pkt_req <= 1'b0;
        end
    end

    // Frame storage needs no reset: it is only read while the matching busy bit is set
    always_ff @(posedge clk) begin
        if (accept) begin
            mb_id[wr_sel]   <= wr_id;
            mb_len[wr_sel]  <= (wr_len > 4'd8) ? 4'd8 : wr_len;
            mb_data[wr_sel] <= wr_data;
        end
    end
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus a randomized
// run checked against a transaction-level mailbox model.
module tb_can_tx_scheduler;
    localparam int N  = 4;
    localparam int RL = 3;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        wr_en = 1'b0, abort_en = 1'b0;
    logic [1:0]  wr_sel = '0, abort_sel = '0;
    logic [10:0] wr_id = '0;
    logic [3:0]  wr_len = '0;
    logic [63:0] wr_data = '0;
    logic [N-1:0] mb_busy, done_pulse, fail_pulse;
    logic        pkt_req, pkt_ack = 1'b0;
    logic [10:0] pkt_id;
    logic [3:0]  pkt_len;
    logic [63:0] pkt_data;
    logic        pkt_done = 1'b0, pkt_lost = 1'b0, pkt_err = 1'b0;

    int checks = 0, errors = 0;

    can_tx_scheduler #(.N_MBOX(N), .RETRY_LIMIT(RL)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id),
        .wr_len(wr_len), .wr_data(wr_data), .abort_en(abort_en), .abort_sel(abort_sel),
        .mb_busy(mb_busy), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
        .pkt_req(pkt_req), .pkt_ack(pkt_ack), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_data(pkt_data), .pkt_done(pkt_done), .pkt_lost(pkt_lost), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mb(input int s, input logic [10:0] id, input logic [3:0] len,
                            input logic [63:0] d);
        wr_en = 1'b1; wr_sel = 2'(s); wr_id = id; wr_len = len; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_req(input int max, output int n, output bit ok);
        n = 0;
        while (!pkt_req && n < max) begin
            tick();
            n++;
        end
        ok = pkt_req;
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    // kind: 0 done, 1 err, 2 lost
    task automatic outcome(input int kind);
        pkt_done = (kind == 0); pkt_err = (kind == 1); pkt_lost = (kind == 2);
        tick();
        pkt_done = 1'b0; pkt_err = 1'b0; pkt_lost = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({mb_busy, done_pulse, fail_pulse, pkt_req, pkt_id, pkt_len, pkt_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b req=%b id=%h len=%h data=%h", mb_busy, pkt_req,
                     pkt_id, pkt_len, pkt_data);
        end
        rstn = 1'b1;
        repeat (2) tick();
        checks++;
        if (mb_busy !== '0 || pkt_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b req=%b expected 0", mb_busy, pkt_req);
        end
    endtask

    task automatic test_single();
        int n; bit ok;
        write_mb(0, 11'h123, 4'd2, 64'hBEEF);
        checks++;
        if (mb_busy !== 4'b0001) begin
            errors++; $display("FAIL single_busy: got %b want 0001", mb_busy);
        end
        wait_req(10, n, ok);
        checks++;
        if (!ok || n != 2) begin
            errors++; $display("FAIL single_latency: req=%b after %0d cycles want 2", ok, n);
        end
        checks++;
        if (pkt_id !== 11'h123 || pkt_len !== 4'd2 || pkt_data !== 64'hBEEF) begin
            errors++;
            $display("FAIL single_fields: id=%h len=%0d data=%h", pkt_id, pkt_len, pkt_data);
        end
        repeat (3) tick();
        checks++;
        if (pkt_req !== 1'b1 || pkt_id !== 11'h123) begin
            errors++; $display("FAIL single_hold: req=%b id=%h", pkt_req, pkt_id);
        end
        ack();
        checks++;
        if (pkt_req !== 1'b0) begin
            errors++; $display("FAIL single_req_drop: req=%b want 0", pkt_req);
        end
        repeat (20) tick();
        outcome(0);
        checks++;
        if (done_pulse !== 4'b0001 || fail_pulse !== 4'b0000 || mb_busy !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: done=%b fail=%b busy=%b", done_pulse, fail_pulse, mb_busy);
        end
        tick();
        checks++;
        if (done_pulse !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width: done=%b want 0000", done_pulse);
        end
    endtask

    task automatic test_priority();
        int n; bit ok;
        logic [10:0] exp_id [3] = '{11'h100, 11'h100, 11'h400};
        logic [63:0] exp_d  [3] = '{64'h11, 64'h22, 64'h00};
        write_mb(0, 11'h400, 4'd1, 64'h00);
        write_mb(1, 11'h100, 4'd1, 64'h11);
        write_mb(2, 11'h100, 4'd1, 64'h22);
        for (int k = 0; k < 3; k++) begin
            wait_req(20, n, ok);
            checks++;
            if (!ok || pkt_id !== exp_id[k] || pkt_data !== exp_d[k]) begin
                errors++;
                $display("FAIL priority_order%0d: req=%b id=%h data=%h want id=%h data=%h", k, ok,
                         pkt_id, pkt_data, exp_id[k], exp_d[k]);
            end
            ack();
            outcome(0);
        end
    endtask

    task automatic test_lost_preempt();
        int n; bit ok;
        write_mb(0, 11'h300, 4'd3, 64'hA0);
        wait_req(10, n, ok);
        ack();
        write_mb(3, 11'h010, 4'd4, 64'hB3);
        outcome(2);
        checks++;
        if (mb_busy !== 4'b1001 || fail_pulse !== 4'b0000) begin
            errors++; $display("FAIL lost_pending: busy=%b fail=%b", mb_busy, fail_pulse);
        end
        wait_req(10, n, ok);
        checks++;
        if (!ok || pkt_id !== 11'h010) begin
            errors++; $display("FAIL lost_preempt: req=%b id=%h want 010", ok, pkt_id);
        end
        ack();
        outcome(0);
        checks++;
        if (done_pulse !== 4'b1000) begin
            errors++; $display("FAIL lost_mb3_done: done=%b want 1000", done_pulse);
        end
        // Three errors must now be needed: the arbitration loss did not count
        for (int k = 0; k < 3; k++) begin
            wait_req(10, n, ok);
            checks++;
            if (!ok || pkt_id !== 11'h300) begin
                errors++; $display("FAIL lost_reoffer%0d: req=%b id=%h want 300", k, ok, pkt_id);
            end
            ack();
            outcome(1);
        end
        checks++;
        if (fail_pulse !== 4'b0001 || mb_busy !== 4'b0000) begin
            errors++; $display("FAIL lost_retry_count: fail=%b busy=%b", fail_pulse, mb_busy);
        end
    endtask

    task automatic test_retry_limit();
        int n, offers; bit ok;
        offers = 0;
        write_mb(1, 11'h222, 4'd8, 64'h5555);
        for (int k = 0; k < 5; k++) begin
            wait_req(10, n, ok);
            if (ok) begin
                offers++;
                ack();
                outcome(1);
            end
        end
        checks++;
        if (offers != RL) begin
            errors++; $display("FAIL retry_offers: got %0d want %0d", offers, RL);
        end
        checks++;
        if (mb_busy !== 4'b0000) begin
            errors++; $display("FAIL retry_busy: busy=%b want 0000", mb_busy);
        end
    endtask

    task automatic test_retry_pulse();
        int n; bit ok;
        write_mb(1, 11'h222, 4'd8, 64'h5555);
        for (int k = 0; k < RL; k++) begin
            wait_req(10, n, ok);
            ack();
            outcome(1);
        end
        checks++;
        if (fail_pulse !== 4'b0010 || done_pulse !== 4'b0000) begin
            errors++; $display("FAIL retry_fail_pulse: fail=%b done=%b", fail_pulse, done_pulse);
        end
    endtask

    task automatic test_abort();
        int n; bit ok;
        for (int rep = 0; rep < 2; rep++) begin
            write_mb(2, 11'h0A0, 4'd1, 64'h7);
            wait_req(10, n, ok);
            abort_en = 1'b1; abort_sel = 2'd2;
            tick();
            abort_en = 1'b0;
            checks++;
            if (mb_busy !== 4'b0100 || fail_pulse !== 4'b0000 || pkt_req !== 1'b1) begin
                errors++;
                $display("FAIL abort_deferred%0d: busy=%b fail=%b req=%b", rep, mb_busy,
                         fail_pulse, pkt_req);
            end
            ack();
            outcome(rep == 0 ? 1 : 0);
            checks++;
            if (rep == 0 && (fail_pulse !== 4'b0100 || done_pulse !== 4'b0000)) begin
                errors++;
                $display("FAIL abort_err: fail=%b done=%b want fail=0100", fail_pulse, done_pulse);
            end else if (rep == 1 && (done_pulse !== 4'b0100 || fail_pulse !== 4'b0000)) begin
                errors++;
                $display("FAIL abort_done: fail=%b done=%b want done=0100", fail_pulse, done_pulse);
            end
            wait_req(8, n, ok);
            checks++;
            if (ok || mb_busy !== 4'b0000) begin
                errors++; $display("FAIL abort_no_retry%0d: req=%b busy=%b", rep, ok, mb_busy);
            end
        end
        // Aborting a waiting, non-selected mailbox fails it immediately
        write_mb(1, 11'h050, 4'd1, 64'h1);
        wait_req(10, n, ok);
        write_mb(3, 11'h060, 4'd1, 64'h3);
        abort_en = 1'b1; abort_sel = 2'd3;
        tick();
        abort_en = 1'b0;
        checks++;
        if (fail_pulse !== 4'b1000 || mb_busy !== 4'b0010) begin
            errors++; $display("FAIL abort_waiting: fail=%b busy=%b", fail_pulse, mb_busy);
        end
        ack();
        outcome(0);
    endtask

    task automatic test_reset_midframe();
        int n; bit ok;
        write_mb(0, 11'h111, 4'd1, 64'h1);
        write_mb(1, 11'h222, 4'd1, 64'h2);
        write_mb(2, 11'h333, 4'd1, 64'h3);
        wait_req(10, n, ok);
        ack();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({mb_busy, done_pulse, fail_pulse, pkt_req, pkt_id, pkt_len, pkt_data} !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b req=%b id=%h", mb_busy, pkt_req, pkt_id);
        end
        tick();
        rstn = 1'b1;
        wait_req(20, n, ok);
        checks++;
        if (ok || mb_busy !== 4'b0000 || done_pulse !== 4'b0000 || fail_pulse !== 4'b0000) begin
            errors++; $display("FAIL reset_no_offer: req=%b busy=%b", ok, mb_busy);
        end
    endtask

    task automatic test_random();
        logic [10:0] m_id [N];
        logic [3:0]  m_len [N];
        logic [63:0] m_data [N];
        bit          m_busy [N];
        int          m_retry [N];
        logic [N-1:0] exp_busy, exp_done, exp_fail;
        int n, cur, kind, best; bit ok;
        for (int round = 0; round < 8; round++) begin
            for (int i = 0; i < N; i++) begin
                m_id[i]    = 11'($urandom_range(0, 2047));
                if (i > 0 && $urandom_range(0, 3) == 0) m_id[i] = m_id[0];
                m_len[i]   = 4'($urandom_range(0, 15));
                m_data[i]  = {$urandom, $urandom};
                m_retry[i] = 0;
                m_busy[i]  = 1'b1;
            end
            write_mb(0, m_id[0], m_len[0], m_data[0]);
            m_len[0] = (m_len[0] > 8) ? 4'd8 : m_len[0];
            wait_req(10, n, ok);
            cur = 0;
            for (int i = 1; i < N; i++) begin
                write_mb(i, m_id[i], m_len[i], m_data[i]);
                m_len[i] = (m_len[i] > 8) ? 4'd8 : m_len[i];
            end
            checks++;
            if (!ok || pkt_id !== m_id[0] || pkt_len !== m_len[0] || pkt_data !== m_data[0]) begin
                errors++;
                $display("FAIL rand_first r%0d: id=%h want %h", round, pkt_id, m_id[0]);
            end
            ack();
            for (int att = 0; att < 100; att++) begin
                repeat ($urandom_range(0, 4)) tick();
                kind = ($urandom_range(0, 9) < 5) ? 0 : ($urandom_range(0, 1) ? 1 : 2);
                outcome(kind);
                exp_done = '0; exp_fail = '0;
                if (kind == 0) begin
                    m_busy[cur] = 1'b0; exp_done[cur] = 1'b1;
                end else if (kind == 1) begin
                    m_retry[cur]++;
                    if (m_retry[cur] == RL) begin
                        m_busy[cur] = 1'b0; exp_fail[cur] = 1'b1;
                    end
                end
                for (int i = 0; i < N; i++) exp_busy[i] = m_busy[i];
                checks++;
                if (mb_busy !== exp_busy || done_pulse !== exp_done || fail_pulse !== exp_fail) begin
                    errors++;
                    $display("FAIL rand_outcome r%0d: busy=%b/%b done=%b/%b fail=%b/%b", round,
                             mb_busy, exp_busy, done_pulse, exp_done, fail_pulse, exp_fail);
                end
                if (exp_busy == '0) break;
                best = -1;
                for (int i = 0; i < N; i++)
                    if (m_busy[i] && (best < 0 || m_id[i] < m_id[best])) best = i;
                wait_req(10, n, ok);
                checks++;
                if (!ok || pkt_id !== m_id[best] || pkt_len !== m_len[best] ||
                    pkt_data !== m_data[best]) begin
                    errors++;
                    $display("FAIL rand_offer r%0d: req=%b id=%h want %h (mb%0d)", round, ok,
                             pkt_id, m_id[best], best);
                end
                cur = best;
                repeat ($urandom_range(0, 3)) tick();
                ack();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_lost_preempt();
        test_retry_limit();
        test_retry_pulse();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
